// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshake signals around mem_arbiter.
//   slave  : arbiter view (request inputs, memory responses in; grants, memory request out)
//   master : environment view (core units plus memory wrapper), the mirror image
// Parameters: AW address width, DW data width; the write mask is DW/8 bits.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned MW = DW / 8;

  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;

  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between the instruction-fetch unit (IFU) and the
// load/store unit (LSU). One transaction at a time: grant (IDLE) -> memory request (REQ) ->
// wait for the response (WAIT) -> one-cycle response pulse to the owner.
// Ports:
//   clk  : clock, everything updates on the rising edge
//   rst  : synchronous active-low reset
//   bus  : mem_arbiter_if.slave, IFU/LSU request+response and memory request+response
//   busy : high whenever a transaction is in flight (state is not IDLE)
// Configuration macro ARB_RR_EN:
//   undefined : fixed priority, LSU over IFU (the LSU holds the older instruction)
//   defined   : round-robin on ties using a 1-bit last-grant register (resets to LSU)
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         busy
);
  localparam int unsigned MW = DW / 8;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIfu, OwnLsu} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q;
  logic [AW-1:0] addr_q;
  logic          wen_q;
  logic [DW-1:0] wdata_q;
  logic [MW-1:0] wmask_q;
  logic          ifu_resp_valid_q, lsu_resp_valid_q;
  logic [DW-1:0] ifu_rdata_q, lsu_rdata_q;
  logic          grant_ifu, grant_lsu;
  logic          idle;
`ifdef ARB_RR_EN
  logic          last_lsu_q;  // 1: the LSU received the most recent grant
`endif

  // Gated by rst so no ready is offered while reset is held.
  assign idle = rst && (state_q == StIdle);

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    state_d   = state_q;
    if (idle) begin
`ifdef ARB_RR_EN
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        grant_ifu = last_lsu_q;
        grant_lsu = !last_lsu_q;
      end else begin
        grant_ifu = bus.ifu_req_valid;
        grant_lsu = bus.lsu_req_valid;
      end
`else
      grant_lsu = bus.lsu_req_valid;
      grant_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
`endif
    end
    unique case (state_q)
      StIdle:  if (grant_ifu || grant_lsu) state_d = StReq;
      StReq:   if (bus.mem_req_ready) state_d = StWait;
      StWait:  if (bus.mem_resp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= StIdle;
      owner_q          <= OwnNone;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
`ifdef ARB_RR_EN
      last_lsu_q       <= 1'b1;
`endif
    end else begin
      state_q          <= state_d;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      if (grant_lsu) begin
        owner_q <= OwnLsu;
        addr_q  <= bus.lsu_addr;
        wen_q   <= bus.lsu_wen;
        wdata_q <= bus.lsu_wdata;
        wmask_q <= bus.lsu_wmask;
      end else if (grant_ifu) begin
        owner_q <= OwnIfu;
        addr_q  <= bus.ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
      // Responses only count in WAIT; a stray strobe elsewhere is dropped.
      if (state_q == StWait && bus.mem_resp_valid) begin
        owner_q <= OwnNone;
        if (owner_q == OwnIfu) begin
          ifu_resp_valid_q <= 1'b1;
          ifu_rdata_q      <= bus.mem_rdata;
        end
        if (owner_q == OwnLsu) begin
          lsu_resp_valid_q <= 1'b1;
          lsu_rdata_q      <= wen_q ? '0 : bus.mem_rdata;
        end
      end
`ifdef ARB_RR_EN
      if (grant_ifu || grant_lsu) last_lsu_q <= grant_lsu;
`endif
    end
  end

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.mem_req_valid  = rst && (state_q == StReq);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset check, a table of directed transactions,
// hand-written spurious-response and mid-transaction-reset sequences, then random traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  string ctx = "";

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv, lv, wen;
    logic [31:0] iaddr, laddr, wdata;
    logic [3:0]  wmask;
    int          rdy_dly, rsp_dly;
    logic [31:0] rdata;
    logic        exp_lsu;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%08h, want 0x%08h (t=%0t)", ctx, name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] ea, ed;
    logic        ew;
    logic [3:0]  em;
    logic        loser_held;
    ea = v.exp_lsu ? v.laddr : v.iaddr;
    ew = v.exp_lsu && v.wen;
    em = v.exp_lsu ? v.wmask : 4'h0;
    ed = ew ? 32'h0 : v.rdata;
    loser_held = v.exp_lsu ? v.iv : v.lv;
    bus.ifu_req_valid = v.iv;  bus.ifu_addr  = v.iaddr;
    bus.lsu_req_valid = v.lv;  bus.lsu_addr  = v.laddr;
    bus.lsu_wen       = v.wen; bus.lsu_wdata = v.wdata; bus.lsu_wmask = v.wmask;
    bus.mem_req_ready = 1'b0;  bus.mem_resp_valid = 1'b0;
    #1;
    chk("grant.ifu_ready", bus.ifu_req_ready, !v.exp_lsu);
    chk("grant.lsu_ready", bus.lsu_req_ready, v.exp_lsu);
    chk("grant.busy", busy, 1'b0);
    step();
    if (v.exp_lsu) bus.lsu_req_valid = 1'b0;
    else bus.ifu_req_valid = 1'b0;
    for (int i = 0; i <= v.rdy_dly; i++) begin
      #1;
      chk("req.mem_req_valid", bus.mem_req_valid, 1'b1);
      chk("req.mem_addr", bus.mem_addr, ea);
      chk("req.mem_wen", bus.mem_wen, ew);
      chk("req.mem_wmask", bus.mem_wmask, em);
      if (v.exp_lsu) chk("req.mem_wdata", bus.mem_wdata, v.wdata);
      chk("req.ready_blocked", bus.ifu_req_ready | bus.lsu_req_ready, 1'b0);
      chk("req.busy", busy, 1'b1);
      if (i == v.rdy_dly) bus.mem_req_ready = 1'b1;
      step();
    end
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i <= v.rsp_dly; i++) begin
      #1;
      chk("wait.mem_req_valid", bus.mem_req_valid, 1'b0);
      chk("wait.no_resp", bus.ifu_resp_valid | bus.lsu_resp_valid, 1'b0);
      chk("wait.ready_blocked", bus.ifu_req_ready | bus.lsu_req_ready, 1'b0);
      if (i == v.rsp_dly) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = v.rdata;
      end
      step();
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'hA5A5_5A5A;
    #1;
    chk("resp.ifu_valid", bus.ifu_resp_valid, !v.exp_lsu);
    chk("resp.lsu_valid", bus.lsu_resp_valid, v.exp_lsu);
    if (v.exp_lsu) chk("resp.lsu_rdata", bus.lsu_rdata, ed);
    else chk("resp.ifu_rdata", bus.ifu_rdata, ed);
    chk("resp.busy", busy, 1'b0);
    // Same-cycle regrant: a waiting loser is offered ready while the pulse is out.
    if (v.exp_lsu) chk("resp.next_ready", bus.ifu_req_ready, loser_held);
    else chk("resp.next_ready", bus.lsu_req_ready, loser_held);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    step();
    chk("post.pulse_width", bus.ifu_resp_valid | bus.lsu_resp_valid, 1'b0);
  endtask

  // Reference model state for the random phase: at most one in-flight transaction.
  int          own;        // 0 none, 1 IFU, 2 LSU
  bit          sent;       // memory has accepted the in-flight request
  logic [31:0] m_addr, m_wdata;
  logic        m_wen;
  logic [3:0]  m_wmask;
  int          pulse_own;
  logic [31:0] pulse_data;
  bit          last_lsu;

  function automatic int pick(input bit iv, input bit lv, input bit last_l);
    if (iv && lv) begin
`ifdef ARB_RR_EN
      return last_l ? 1 : 2;
`else
      return 2;
`endif
    end
    if (lv) return 2;
    if (iv) return 1;
    return 0;
  endfunction

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 4'h0, 0, 0,
                32'h0010_0073, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 3, 0,
                32'h1357_9BDF, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_2004, 32'h0, 4'h3, 1, 2,
                32'h1234_5678, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h8000_3000, 32'h0, 4'hF, 0, 1,
                32'hCAFE_0001, !RR};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 32'h8000_3004, 32'h0BAD_F00D, 4'h5, 2, 0,
                32'hCAFE_0002, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0018, 32'h8000_3008, 32'h0, 4'hC, 0, 0,
                32'hCAFE_0003, !RR};

    // Reset with both requesters asking.
    ctx = "reset";
    clear_inputs();
    rst = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    step();
    step();
    #1;
    chk("ifu_req_ready", bus.ifu_req_ready, 1'b0);
    chk("lsu_req_ready", bus.lsu_req_ready, 1'b0);
    chk("mem_req_valid", bus.mem_req_valid, 1'b0);
    chk("mem_addr", bus.mem_addr, 32'h0);
    chk("mem_wen", bus.mem_wen, 1'b0);
    chk("mem_wdata", bus.mem_wdata, 32'h0);
    chk("mem_wmask", bus.mem_wmask, 4'h0);
    chk("resp_valids", bus.ifu_resp_valid | bus.lsu_resp_valid, 1'b0);
    chk("ifu_rdata", bus.ifu_rdata, 32'h0);
    chk("lsu_rdata", bus.lsu_rdata, 32'h0);
    chk("busy", busy, 1'b0);
    clear_inputs();
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      ctx = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Spurious response strobes in IDLE and in REQ.
    ctx = "spurious";
    clear_inputs();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0BAD;
    step();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("idle.no_resp", bus.ifu_resp_valid | bus.lsu_resp_valid, 1'b0);
    chk("idle.busy", busy, 1'b0);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_4000;
    step();
    bus.lsu_req_valid  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    step();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("req.mem_req_valid", bus.mem_req_valid, 1'b1);
    chk("req.busy", busy, 1'b1);
    chk("req.no_resp", bus.ifu_resp_valid | bus.lsu_resp_valid, 1'b0);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    #1;
    chk("wait.mem_req_valid", bus.mem_req_valid, 1'b0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_CAFE;
    step();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("done.lsu_resp", bus.lsu_resp_valid, 1'b1);
    chk("done.lsu_rdata", bus.lsu_rdata, 32'h0000_CAFE);
    step();

    // Reset during WAIT, then a late response.
    ctx = "abort";
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0040;
    step();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    #1;
    chk("wait.busy", busy, 1'b1);
    rst = 1'b0;
    step();
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.mem_req_valid", bus.mem_req_valid, 1'b0);
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b1;
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1111_1111;
    step();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("late.no_resp", bus.ifu_resp_valid | bus.lsu_resp_valid, 1'b0);
    chk("late.busy", busy, 1'b0);
    step();
    chk("late.no_resp2", bus.ifu_resp_valid | bus.lsu_resp_valid, 1'b0);

    // Random traffic against the reference model, starting from a fresh reset.
    ctx = "random";
    clear_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    own = 0; sent = 1'b0; pulse_own = 0; pulse_data = '0; last_lsu = 1'b1;
    m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wmask = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int win;
      int new_pulse;
      if (!bus.ifu_req_valid && ($urandom % 2 == 0)) begin
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = $urandom;
      end
      if (!bus.lsu_req_valid && ($urandom % 2 == 0)) begin
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = $urandom;
        bus.lsu_wen       = 1'($urandom % 2);
        bus.lsu_wdata     = $urandom;
        bus.lsu_wmask     = 4'($urandom % 16);
      end
      bus.mem_req_ready  = 1'($urandom % 2);
      bus.mem_resp_valid = 1'($urandom % 2);
      bus.mem_rdata      = $urandom;
      #1;
      win = (own == 0) ? pick(bus.ifu_req_valid, bus.lsu_req_valid, last_lsu) : 0;
      chk("ifu_req_ready", bus.ifu_req_ready, win == 1);
      chk("lsu_req_ready", bus.lsu_req_ready, win == 2);
      chk("busy", busy, own != 0);
      chk("mem_req_valid", bus.mem_req_valid, (own != 0) && !sent);
      if (own != 0 && !sent) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wen", bus.mem_wen, m_wen);
        chk("mem_wmask", bus.mem_wmask, m_wmask);
        if (own == 2) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("ifu_resp_valid", bus.ifu_resp_valid, pulse_own == 1);
      chk("lsu_resp_valid", bus.lsu_resp_valid, pulse_own == 2);
      if (pulse_own == 1) chk("ifu_rdata", bus.ifu_rdata, pulse_data);
      if (pulse_own == 2) chk("lsu_rdata", bus.lsu_rdata, pulse_data);
      new_pulse = 0;
      if (own != 0 && sent && bus.mem_resp_valid) begin
        new_pulse  = own;
        pulse_data = (own == 2 && m_wen) ? 32'h0 : bus.mem_rdata;
        own        = 0;
      end else if (own != 0 && !sent && bus.mem_req_ready) begin
        sent = 1'b1;
      end else if (win != 0) begin
        own      = win;
        sent     = 1'b0;
        last_lsu = (win == 2);
        if (win == 2) begin
          m_addr = bus.lsu_addr; m_wen = bus.lsu_wen;
          m_wdata = bus.lsu_wdata; m_wmask = bus.lsu_wmask;
        end else begin
          m_addr = bus.ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = 4'h0;
        end
      end
      pulse_own = new_pulse;
      step();
      if (win == 1) bus.ifu_req_valid = 1'b0;
      if (win == 2) bus.lsu_req_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
